pcie_us_axi_dma_rd_splitter: RTL
================================

# pcie_us_axi_dma_rd_splitter

Upstream descriptor stage for the UltraScale PCIe AXI read DMA engine. Accepts one large read descriptor (PCIe source, AXI destination, length, tag), slices it into bounded chunk descriptors, and issues them to the DMA engine's `s_axis_read_desc_*` port. Counts the per-chunk status returns and emits one status with the original tag once every chunk has completed. Keeps request sizing and outstanding-operation throttling out of the DMA engine's operation table.

## Interface
Parameters:
- `PCIE_ADDR_WIDTH`, 64, PCIe address width
- `AXI_ADDR_WIDTH`, 64, AXI address width
- `LEN_WIDTH`, 20, byte length width (input and chunk)
- `TAG_WIDTH`, 8, tag width (input, chunk and status)
- `SEG_LEN`, 4096, maximum chunk bytes; power of two; must be ≤ 2**(LEN_WIDTH-1)
- `MAX_OUTSTANDING`, 16, maximum chunks issued without status; ≥1

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_axis_read_desc_pcie_addr`  in  PCIE_ADDR_WIDTH  source PCIe address
- `s_axis_read_desc_axi_addr`  in  AXI_ADDR_WIDTH  destination AXI address
- `s_axis_read_desc_len`  in  LEN_WIDTH  total bytes
- `s_axis_read_desc_tag`  in  TAG_WIDTH  caller tag
- `s_axis_read_desc_valid` / `_ready`  in / out  1  input handshake
- `m_axis_read_desc_status_tag`  out  TAG_WIDTH  caller tag of the finished descriptor
- `m_axis_read_desc_status_valid`  out  1  single-cycle completion pulse; no backpressure
- `m_axis_dma_desc_pcie_addr` / `_axi_addr` / `_len` / `_tag`  out  widths as above  chunk descriptor to DMA engine
- `m_axis_dma_desc_valid` / `_ready`  out / in  1  chunk handshake
- `s_axis_dma_desc_status_tag`  in  TAG_WIDTH  chunk status tag (informational)
- `s_axis_dma_desc_status_valid`  in  1  one chunk completed
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: `s_axis_read_desc_ready`=1.
  - On accept with len≠0: latch pcie_addr, axi_addr, remaining=len, caller tag; go to ISSUE.
  - On accept with len=0: no chunk is issued; go to WAIT.
- ISSUE:
  - Chunk length = min(remaining, limit). Limit is set by the Configuration macro.
  - Chunk tag = value of a free-running TAG_WIDTH chunk counter. The counter increments per chunk handshake, wraps modulo 2**TAG_WIDTH, and is not cleared between descriptors.
  - On `m_axis_dma_desc_valid & _ready`: pcie_addr += chunk, axi_addr += chunk, remaining -= chunk, outstanding += 1.
  - When the last chunk (remaining==chunk) hands off, go to WAIT.
- Throttle: `m_axis_dma_desc_valid` is forced low while outstanding == MAX_OUTSTANDING.
- Outstanding counter:
  - `s_axis_dma_desc_status_valid` decrements it.
  - A handshake and a status in the same cycle leave it unchanged.
  - A status while outstanding==0 is ignored; the counter does not underflow.
- WAIT: when outstanding==0 (including the zero-length case), pulse status with the caller tag and go to IDLE.
- Chunk status tags are not checked; completion is by count only.
- Address arithmetic wraps modulo 2**width. Chunk length is never 0.

## Timing
- Reset values: `s_axis_read_desc_ready`=0 while `rst` is high, then 1 in IDLE. All other outputs are 0. Chunk counter=0, outstanding=0, state IDLE.
- All outputs are registered.
- First chunk valid appears the cycle after input accept.
- Chunks issue back-to-back, one per cycle, while ready is high and not throttled.
- Chunk fields stay stable while valid is high and ready is low.
- Status pulse occurs one cycle after the cycle in which outstanding is 0 in WAIT. Input ready rises together with the status pulse.
- Zero-length descriptor: status pulse 2 cycles after accept.
- Statuses arriving in ISSUE are counted normally.
- Asserting `rst` mid-operation drops the operation without a status pulse.

## Configuration
- `PCIE_DMA_RD_SPLIT_ALIGN_EN` defined: limit = SEG_LEN − (pcie_addr mod SEG_LEN). Chunks never cross a SEG_LEN boundary of the PCIe address, so the first chunk may be short.
- Not defined: limit = SEG_LEN. Every chunk except the last is exactly SEG_LEN, regardless of alignment.

## Test plan
- pcie 0x1000, axi 0x0, len 0x3000, tag 0x5A, ready always high, status 4 cycles after each chunk:
  - Response: chunks (0x1000,0x0,0x1000,t0), (0x2000,0x1000,0x1000,t1), (0x3000,0x2000,0x1000,t2) on consecutive cycles.
  - One status pulse tag 0x5A after the third chunk status.
- Macro defined, pcie 0x0F00, len 0x400 -> chunks len 0x100 @0x0F00 and 0x300 @0x1000. Macro undefined: a single 0x400 chunk.
- MAX_OUTSTANDING=2, len 5×SEG_LEN, no statuses -> exactly 2 chunks issue and valid stays low. Each status releases one more chunk. Final status after 5 statuses.
- len 0, tag 0x11 -> no chunk valid; status tag 0x11 two cycles after accept; ready high again in the same cycle.
- Chunk handshake and status in the same cycle with outstanding=1 -> outstanding stays 1. A spurious status in IDLE leaves outstanding at 0.
- `rst` asserted in ISSUE after 1 of 3 chunks -> outputs 0 immediately, no status pulse. Next descriptor's first chunk tag continues at 0 (counter reset).

Source files
------------

// File: rtl/pcie_us_axi_dma_rd_splitter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_us_axi_dma_rd_splitter
// Purpose  : Descriptor splitter placed ahead of the UltraScale PCIe AXI read
//            DMA engine. Takes one large read descriptor, cuts it into chunks
//            of at most SEG_LEN bytes and issues them one per cycle, limiting
//            the number of chunks in flight to MAX_OUTSTANDING. Chunk statuses
//            are counted, and one status carrying the caller tag is returned
//            after every chunk has completed.
// Option   : PCIE_DMA_RD_SPLIT_ALIGN_EN -- when defined, a chunk never crosses
//            a SEG_LEN boundary of the PCIe address, so the first chunk may be
//            short. When undefined, every chunk except the last is SEG_LEN.
// Ports    : clk, rst                      clock, async active-high reset
//            s_axis_read_desc_*            input descriptor (valid/ready)
//            m_axis_read_desc_status_*     completion pulse with caller tag
//            m_axis_dma_desc_*             chunk descriptor to DMA engine
//            s_axis_dma_desc_status_*      per-chunk completion from engine
//            busy                          high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module pcie_us_axi_dma_rd_splitter #(
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8,
    parameter int SEG_LEN         = 4096,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [PCIE_ADDR_WIDTH-1:0] s_axis_read_desc_pcie_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axis_read_desc_axi_addr,
    input  logic [LEN_WIDTH-1:0]       s_axis_read_desc_len,
    input  logic [TAG_WIDTH-1:0]       s_axis_read_desc_tag,
    input  logic                       s_axis_read_desc_valid,
    output logic                       s_axis_read_desc_ready,

    output logic [TAG_WIDTH-1:0]       m_axis_read_desc_status_tag,
    output logic                       m_axis_read_desc_status_valid,

    output logic [PCIE_ADDR_WIDTH-1:0] m_axis_dma_desc_pcie_addr,
    output logic [AXI_ADDR_WIDTH-1:0]  m_axis_dma_desc_axi_addr,
    output logic [LEN_WIDTH-1:0]       m_axis_dma_desc_len,
    output logic [TAG_WIDTH-1:0]       m_axis_dma_desc_tag,
    output logic                       m_axis_dma_desc_valid,
    input  logic                       m_axis_dma_desc_ready,

    input  logic [TAG_WIDTH-1:0]       s_axis_dma_desc_status_tag,
    input  logic                       s_axis_dma_desc_status_valid,

    output logic                       busy
);

    localparam int                   c_OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_OUT_W-1:0]   c_MAX_OUT = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [LEN_WIDTH-1:0] c_SEG_LEN = LEN_WIDTH'(SEG_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    // Address registers hold the address of the chunk currently presented.
    logic [PCIE_ADDR_WIDTH-1:0] r_pcie_addr;
    logic [AXI_ADDR_WIDTH-1:0]  r_axi_addr;
    // Bytes left, including the chunk currently presented.
    logic [LEN_WIDTH-1:0]       r_remaining;
    logic [LEN_WIDTH-1:0]       r_dma_len;
    logic [TAG_WIDTH-1:0]       r_caller_tag;
    logic [TAG_WIDTH-1:0]       r_chunk_cnt;
    logic [c_OUT_W-1:0]         r_outstanding;
    logic                       r_in_ready;
    logic                       r_dma_valid;
    logic                       r_status_valid;
    logic                       r_busy;

    logic                       w_accept;
    logic                       w_hs;
    logic                       w_last;
    logic                       w_status_dec;
    logic [c_OUT_W-1:0]         w_out_next;
    logic [PCIE_ADDR_WIDTH-1:0] w_next_pcie;
    logic [AXI_ADDR_WIDTH-1:0]  w_next_axi;
    logic [LEN_WIDTH-1:0]       w_next_rem;
    logic [LEN_WIDTH-1:0]       w_acc_limit;
    logic [LEN_WIDTH-1:0]       w_next_limit;
    logic [LEN_WIDTH-1:0]       w_acc_len;
    logic [LEN_WIDTH-1:0]       w_next_len;
    logic                       w_unused_status_tag;

    function automatic logic [LEN_WIDTH-1:0] f_min(
        input logic [LEN_WIDTH-1:0] a,
        input logic [LEN_WIDTH-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    // Completion is tracked by count only; the chunk status tag is not used.
    assign w_unused_status_tag = ^s_axis_dma_desc_status_tag;

    assign w_accept     = s_axis_read_desc_valid & r_in_ready;
    // Valid is only ever raised in ISSUE, so a handshake implies ISSUE.
    assign w_hs         = r_dma_valid & m_axis_dma_desc_ready;
    assign w_last       = (r_remaining == r_dma_len);
    // A status with nothing outstanding is stray and must not underflow.
    assign w_status_dec = s_axis_dma_desc_status_valid & (r_outstanding != '0);

    always_comb begin
        w_out_next = r_outstanding;
        case ({w_hs, w_status_dec})
            2'b10:   w_out_next = r_outstanding + 1'b1;
            2'b01:   w_out_next = r_outstanding - 1'b1;
            default: w_out_next = r_outstanding;
        endcase
    end

    // Address/length of the chunk that follows the one being handed off.
    assign w_next_pcie = r_pcie_addr + PCIE_ADDR_WIDTH'(r_dma_len);
    assign w_next_axi  = r_axi_addr + AXI_ADDR_WIDTH'(r_dma_len);
    assign w_next_rem  = r_remaining - r_dma_len;

`ifdef PCIE_DMA_RD_SPLIT_ALIGN_EN
    localparam logic [PCIE_ADDR_WIDTH-1:0] c_SEG_MASK = PCIE_ADDR_WIDTH'(SEG_LEN - 1);
    // Bytes left before the next SEG_LEN boundary of the PCIe address.
    assign w_acc_limit  = c_SEG_LEN - LEN_WIDTH'(s_axis_read_desc_pcie_addr & c_SEG_MASK);
    assign w_next_limit = c_SEG_LEN - LEN_WIDTH'(w_next_pcie & c_SEG_MASK);
`else
    assign w_acc_limit  = c_SEG_LEN;
    assign w_next_limit = c_SEG_LEN;
`endif

    assign w_acc_len  = f_min(s_axis_read_desc_len, w_acc_limit);
    assign w_next_len = f_min(w_next_rem, w_next_limit);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (s_axis_read_desc_len != '0) ? ST_ISSUE : ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (w_hs && w_last) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_outstanding == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcie_addr    <= '0;
            r_axi_addr     <= '0;
            r_remaining    <= '0;
            r_dma_len      <= '0;
            r_caller_tag   <= '0;
            r_chunk_cnt    <= '0;
            r_outstanding  <= '0;
            r_in_ready     <= 1'b0;
            r_dma_valid    <= 1'b0;
            r_status_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_outstanding  <= w_out_next;
            r_in_ready     <= (w_state_next == ST_IDLE);
            r_busy         <= (w_state_next != ST_IDLE);
            // Valid is computed one cycle ahead against the updated count so
            // the throttle takes effect on the very next cycle.
            r_dma_valid    <= (w_state_next == ST_ISSUE) && (w_out_next != c_MAX_OUT);
            r_status_valid <= (r_state == ST_WAIT) && (r_outstanding == '0);

            if (w_accept) begin
                r_pcie_addr  <= s_axis_read_desc_pcie_addr;
                r_axi_addr   <= s_axis_read_desc_axi_addr;
                r_remaining  <= s_axis_read_desc_len;
                r_dma_len    <= w_acc_len;
                r_caller_tag <= s_axis_read_desc_tag;
            end

            if (w_hs) begin
                r_pcie_addr <= w_next_pcie;
                r_axi_addr  <= w_next_axi;
                r_remaining <= w_next_rem;
                r_dma_len   <= w_next_len;
                r_chunk_cnt <= r_chunk_cnt + 1'b1;
            end
        end
    end

    assign s_axis_read_desc_ready        = r_in_ready;
    assign m_axis_read_desc_status_tag   = r_caller_tag;
    assign m_axis_read_desc_status_valid = r_status_valid;
    assign m_axis_dma_desc_pcie_addr     = r_pcie_addr;
    assign m_axis_dma_desc_axi_addr      = r_axi_addr;
    assign m_axis_dma_desc_len           = r_dma_len;
    assign m_axis_dma_desc_tag           = r_chunk_cnt;
    assign m_axis_dma_desc_valid         = r_dma_valid;
    assign busy                          = r_busy;

endmodule
`default_nettype wire
